pwm_sequencer: RTL and testbench
================================

// Module: pwm_sequencer
// PURPOSE
// - Downstream consumer of the serially programmed duty-cycle memory.
// - After the memory reports programmed, walks its entries 0..last_i and emits one PWM period per entry.
// - Repeats each entry repeat_i+1 times, then wraps.
// - Drives the memory read address; takes its WIDTH-bit parallel read data as the duty cycle.
// PARAMETERS
// - WIDTH       7   duty/memory word width; PWM period = 2**WIDTH-1 ticks
// - DEPTH       32  memory entries; ADDR_W = $clog2(DEPTH)
// - PRESCALE_W  8   width of prescale_i
// PORTS
// - clk           in   1           single clock, rising edge
// - rst           in   1           synchronous reset, active-high
// - programmed_i  in   1           memory holds a valid program; enables sequencing
// - data_i        in   WIDTH       memory read data for addr_o (combinational, 0-cycle)
// - addr_o        out  ADDR_W      memory read address (prefetch pointer)
// - prescale_i    in   PRESCALE_W  tick every prescale_i+1 clk cycles
// - repeat_i      in   4           periods per entry minus one
// - last_i        in   ADDR_W      index of final entry in the sequence
// - pwm_o         out  1           PWM output
// - step_o        out  1           1-cycle pulse when a new entry's duty is latched
// - idx_o         out  ADDR_W      index of the entry currently played
// BEHAVIOUR
// - Reset (rst=1 on a clk edge): state IDLE.
//   - Outputs: addr_o=0, idx_o=0, pwm_o=0, step_o=0.
//   - Internal: all counters=0, duty_q=0.
// - FSM IDLE -> LOAD -> RUN.
//   - IDLE: addr_o=0. programmed_i=1 -> LOAD.
//   - LOAD (1 cycle): duty_q<=data_i, idx_o<=addr_o, addr_o<=next(addr_o), step_o=1; -> RUN.
//   - RUN: PWM active. programmed_i=0 -> IDLE next cycle, from any state, with priority over all else.
// - next(a) = 0 if a==last_i or a==DEPTH-1, else a+1. addr_o always points at the entry to play next.
// - Prescaler: pre_cnt counts up each cycle in RUN.
//   - tick when pre_cnt>=prescale_i, then pre_cnt<=0.
//   - The >= compare makes a mid-run decrease of prescale_i safe.
// - Period counter pwm_cnt (WIDTH bits) advances per tick, 0..2**WIDTH-2, then wraps to 0.
// - pwm_o = (state==RUN) && (pwm_cnt < duty_q).
//   - Decoded from registers only; no input->output combinational path.
//   - duty 0 -> always low; duty 2**WIDTH-1 -> always high.
// - Period end = tick while pwm_cnt==2**WIDTH-2.
//   - If rep_cnt==repeat_i: duty_q<=data_i, idx_o<=addr_o, addr_o<=next(addr_o), rep_cnt<=0, step_o=1.
//   - Else: rep_cnt++, duty_q unchanged.
// - duty_q changes only at period boundaries (glitch-free). repeat_i and last_i are sampled only at boundaries.
// - Latency: programmed_i sampled 1 at edge N -> LOAD at N+1 -> RUN from N+2.
//   - pwm_o first valid in cycle N+2.
// - last_i=0: single entry played forever.
// - programmed_i dropping mid-period: pwm_o=0 next cycle, all counters cleared; re-assertion restarts at entry 0.
// CONFIGURATION
// - Macro PWM_SEQ_ONESHOT_EN.
// - Defined:
//   - Adds ports oneshot_i (in, 1) and done_o (out, 1, reset 0).
//   - With oneshot_i=1: at the period end that would wrap from entry last_i, go to DONE (pwm_o=0, done_o=1).
//   - Leave DONE only via programmed_i=0 (-> IDLE) or rst.
// - Undefined: ports absent, no DONE state, sequence always wraps.
// TESTING
// - Reset: rst=1 for 2 cycles with programmed_i=1 -> pwm_o=0, addr_o=0, step_o=0; LOAD 1 cycle after rst release.
// - Entry0=64, prescale 0, repeat 0, last 0 -> pwm_o high 64 / low 63 cycles, period 127, step_o every 127 cycles.
// - Entries {0,127,1}, last_i=2 -> period 1 all low, period 2 all high, period 3 high 1 cycle, then wraps to entry 0.
// - Entries {10,20,30}, last_i=2, repeat_i=1 -> duties 10,10,20,20,30,30,10,...; idx_o 0,1,2,0.
// - prescale_i=3, duty 1 -> pwm_o high 4 cycles per 508-cycle period.
// - programmed_i=0 mid-period -> pwm_o=0 next cycle, addr_o=0; ONESHOT_EN with oneshot_i=1 and last_i=1 -> done_o=1 after 2 periods.

Source files
------------

// File: rtl/pwm_sequencer.sv
// Sequencer that steps through a duty-cycle memory and plays one PWM period per entry.
// Define PWM_SEQ_ONESHOT_EN to add oneshot_i/done_o, which stop the sequence after the last entry.
module pwm_sequencer #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned PRESCALE_W = 8,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  programmed_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic [ADDR_W-1:0]     addr_o,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [3:0]            repeat_i,
  input  logic [ADDR_W-1:0]     last_i,
`ifdef PWM_SEQ_ONESHOT_EN
  input  logic                  oneshot_i,
  output logic                  done_o,
`endif
  output logic                  pwm_o,
  output logic                  step_o,
  output logic [ADDR_W-1:0]     idx_o
);

`ifdef PWM_SEQ_ONESHOT_EN
  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
`endif

  localparam logic [WIDTH-1:0]  CntMax  = WIDTH'((1 << WIDTH) - 2);
  localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(DEPTH - 1);

  state_e                state_q;
  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [WIDTH-1:0]      pwm_cnt_q;
  logic [WIDTH-1:0]      duty_q;
  logic [3:0]            rep_cnt_q;
  logic                  tick;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] last);
    return ((a == last) || (a == AddrMax)) ? '0 : a + ADDR_W'(1);
  endfunction

  // >= rather than == so a prescale decrease mid-count still produces a tick.
  assign tick  = (pre_cnt_q >= prescale_i);
  assign pwm_o = (state_q == StRun) && (pwm_cnt_q < duty_q);

`ifdef PWM_SEQ_ONESHOT_EN
  logic wrap;
  assign wrap = (idx_o == last_i) || (idx_o == AddrMax);
`endif

  always_ff @(posedge clk) begin
    if (rst || !programmed_i) begin
      state_q   <= StIdle;
      addr_o    <= '0;
      idx_o     <= '0;
      step_o    <= 1'b0;
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      rep_cnt_q <= '0;
      duty_q    <= '0;
`ifdef PWM_SEQ_ONESHOT_EN
      done_o    <= 1'b0;
`endif
    end else begin
      step_o <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StLoad;
        StLoad: begin
          duty_q  <= data_i;
          idx_o   <= addr_o;
          addr_o  <= next_addr(addr_o, last_i);
          step_o  <= 1'b1;
          state_q <= StRun;
        end
        StRun: begin
          if (tick) begin
            pre_cnt_q <= '0;
            if (pwm_cnt_q == CntMax) begin
              pwm_cnt_q <= '0;
              if (rep_cnt_q == repeat_i) begin
                rep_cnt_q <= '0;
`ifdef PWM_SEQ_ONESHOT_EN
                if (oneshot_i && wrap) begin
                  state_q <= StDone;
                  done_o  <= 1'b1;
                end else begin
                  duty_q <= data_i;
                  idx_o  <= addr_o;
                  addr_o <= next_addr(addr_o, last_i);
                  step_o <= 1'b1;
                end
`else
                duty_q <= data_i;
                idx_o  <= addr_o;
                addr_o <= next_addr(addr_o, last_i);
                step_o <= 1'b1;
`endif
              end else begin
                rep_cnt_q <= rep_cnt_q + 4'd1;
              end
            end else begin
              pwm_cnt_q <= pwm_cnt_q + WIDTH'(1);
            end
          end else begin
            pre_cnt_q <= pre_cnt_q + PRESCALE_W'(1);
          end
        end
`ifdef PWM_SEQ_ONESHOT_EN
        StDone: state_q <= StDone;
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: arithmetic reference model checked every cycle, directed literal checks,
// then randomized programs. Exercises oneshot when PWM_SEQ_ONESHOT_EN is defined.
module tb_pwm_sequencer;
  localparam int WIDTH = 7;
  localparam int DEPTH = 32;
  localparam int PRESCALE_W = 8;
  localparam int ADDR_W = 5;
  localparam int NTICK = 127;

  logic clk = 1'b0;
  logic rst, programmed;
  logic [WIDTH-1:0] data;
  logic [ADDR_W-1:0] addr, last, idx;
  logic [PRESCALE_W-1:0] prescale;
  logic [3:0] rpt;
  logic pwm, step, os_on;
  logic [WIDTH-1:0] mem [DEPTH];
`ifdef PWM_SEQ_ONESHOT_EN
  logic oneshot, done;
  assign os_on = oneshot;
`else
  assign os_on = 1'b0;
`endif

  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;
  int mst = 0;  // 0 idle, 1 load, 2 run, 3 done
  int k = 0;    // cycles spent in run

  int exp_hi2[4] = '{0, 127, 1, 0};
  int exp_idx2[4] = '{0, 1, 2, 0};
  int exp_hi3[7] = '{10, 10, 20, 20, 30, 30, 10};
  int exp_idx3[7] = '{0, 0, 1, 1, 2, 2, 0};
  int exp_st3[7] = '{1, 0, 1, 0, 1, 0, 1};

  assign data = mem[addr];
  always #5 clk = ~clk;

  pwm_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk(clk),
    .rst(rst),
    .programmed_i(programmed),
    .data_i(data),
    .addr_o(addr),
    .prescale_i(prescale),
    .repeat_i(rpt),
    .last_i(last),
`ifdef PWM_SEQ_ONESHOT_EN
    .oneshot_i(oneshot),
    .done_o(done),
`endif
    .pwm_o(pwm),
    .step_o(step),
    .idx_o(idx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int total_run_len();
    return (int'(last) + 1) * (int'(rpt) + 1) * NTICK * (int'(prescale) + 1);
  endfunction

  // Reference state: only tracks idle/load/run/done and elapsed run cycles.
  always @(posedge clk) begin
    if (rst || !programmed) begin
      mst <= 0;
      k   <= 0;
    end else begin
      case (mst)
        0: mst <= 1;
        1: begin mst <= 2; k <= 0; end
        2: if (os_on && (k + 1) == total_run_len()) mst <= 3; else k <= k + 1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic e_pwm, e_step, e_done;
    int e_idx, e_addr, plen, p, r, cnt, e;
    e_pwm = 1'b0; e_step = 1'b0; e_done = 1'b0; e_idx = 0; e_addr = 0;
    if (chk_en) begin
      if (mst == 2) begin
        plen   = NTICK * (int'(prescale) + 1);
        p      = k / plen;
        r      = k % plen;
        cnt    = r / (int'(prescale) + 1);
        e      = (p / (int'(rpt) + 1)) % (int'(last) + 1);
        e_pwm  = (cnt < int'(mem[e]));
        e_step = (r == 0) && (p % (int'(rpt) + 1) == 0);
        e_idx  = e;
        e_addr = (e == int'(last)) ? 0 : e + 1;
      end else if (mst == 3) begin
        e_done = 1'b1;
        e_idx  = int'(last);
      end
      check("pwm", 32'(pwm), 32'(e_pwm));
      check("step", 32'(step), 32'(e_step));
      check("idx", 32'(idx), e_idx);
      check("addr", 32'(addr), e_addr);
`ifdef PWM_SEQ_ONESHOT_EN
      check("done", 32'(done), 32'(e_done));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic measure(input int n, output int hi, output int st);
    hi = 0; st = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm === 1'b1) hi++;
      if (step === 1'b1) st++;
      cyc(1);
    end
  endtask

  task automatic stop_and_clear();
    programmed = 1'b0;
    cyc(1);
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  initial begin
    int hi, st, runlen;
    rst = 1'b1; programmed = 1'b1; prescale = '0; rpt = '0; last = '0;
`ifdef PWM_SEQ_ONESHOT_EN
    oneshot = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 7'd64;
    cyc(2);
    chk_en = 1'b1;
    check("rst_pwm", 32'(pwm), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_step", 32'(step), 0);
    check("rst_idx", 32'(idx), 0);
    rst = 1'b0;
    cyc(1);
    check("load_step", 32'(step), 0);
    cyc(1);
    check("run_first_step", 32'(step), 1);
    check("run_first_pwm", 32'(pwm), 1);
    measure(NTICK, hi, st);
    check("duty64_high", hi, 64);
    check("duty64_steps", st, 1);
    check("duty64_next_step", 32'(step), 1);
    cyc(30);
    check("pre_drop_pwm", 32'(pwm), 1);
    programmed = 1'b0;
    cyc(1);
    check("drop_pwm", 32'(pwm), 0);
    check("drop_addr", 32'(addr), 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 7'd0; mem[1] = 7'd127; mem[2] = 7'd1; last = 5'd2;
    programmed = 1'b1;
    cyc(2);
    for (int j = 0; j < 4; j++) begin
      check("seq3_idx", 32'(idx), exp_idx2[j]);
      measure(NTICK, hi, st);
      check("seq3_high", hi, exp_hi2[j]);
    end

    stop_and_clear();
    mem[0] = 7'd10; mem[1] = 7'd20; mem[2] = 7'd30; rpt = 4'd1;
    programmed = 1'b1;
    cyc(2);
    for (int j = 0; j < 7; j++) begin
      check("rep_idx", 32'(idx), exp_idx3[j]);
      measure(NTICK, hi, st);
      check("rep_high", hi, exp_hi3[j]);
      check("rep_step", st, exp_st3[j]);
    end

    stop_and_clear();
    mem[0] = 7'd1; prescale = 8'd3; rpt = 4'd0; last = 5'd0;
    programmed = 1'b1;
    cyc(2);
    measure(508, hi, st);
    check("pre3_high", hi, 4);
    check("pre3_steps", st, 1);
    check("pre3_next_step", 32'(step), 1);

`ifdef PWM_SEQ_ONESHOT_EN
    stop_and_clear();
    mem[0] = 7'd50; mem[1] = 7'd60; prescale = '0; last = 5'd1; oneshot = 1'b1;
    programmed = 1'b1;
    cyc(2);
    cyc(253);
    check("oneshot_not_yet", 32'(done), 0);
    cyc(1);
    check("oneshot_done", 32'(done), 1);
    check("oneshot_pwm", 32'(pwm), 0);
    cyc(10);
    check("oneshot_hold", 32'(done), 1);
    programmed = 1'b0;
    cyc(1);
    check("oneshot_clear", 32'(done), 0);
    oneshot = 1'b0;
`endif

    for (int it = 0; it < 16; it++) begin
      stop_and_clear();
      cyc($urandom_range(0, 3));
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom % 4)
          0: mem[i] = 7'd0;
          1: mem[i] = 7'd127;
          default: mem[i] = 7'($urandom_range(0, 127));
        endcase
      end
      prescale = 8'($urandom_range(0, 2));
      rpt = 4'($urandom_range(0, 2));
      last = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      runlen = $urandom_range(50, 2500);
`ifdef PWM_SEQ_ONESHOT_EN
      oneshot = 1'($urandom % 2);
      if (oneshot) begin
        prescale = '0;
        rpt = 4'($urandom_range(0, 1));
        last = 5'($urandom_range(0, 2));
        runlen = $urandom_range(300, 1000);
      end
`endif
      programmed = 1'b1;
      cyc(runlen);
    end
    programmed = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
